pipeline_hazard_ctrl: RTL and testbench

Hazard and stall controller for the five-stage pipeline. It sequences the IF/ID and ID/EX pipeline registers. It detects load-use hazards, flushes wrong-path instructions on a taken branch, and holds dependent instructions while the iterative multiply/divide unit is busy. It sits beside the ID stage, and its outputs drive the PC write enable, the IF/ID write and flush controls, and the ID/EX bubble insert that zeroes the WB/M/EX control fields.

---
 rtl/pipeline_hazard_ctrl_if.sv | 36 +++
 rtl/pipeline_hazard_ctrl.sv | 102 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the ID-stage hazard controller and the pipeline.
// The controller uses the slave modport; the pipeline side uses master.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned REG_BITS = 5
);
  logic [REG_BITS-1:0] idRs;
  logic [REG_BITS-1:0] idRt;
  logic                idUsesRt;
  logic                idUsesHiLo;
  logic                idMdStart;
  logic                exMemRead;
  logic [REG_BITS-1:0] exRt;
  logic                exMdStart;
  logic                branchTaken;
  logic                pcWrite;
  logic                ifidWrite;
  logic                ifidFlush;
  logic                idexBubble;
  logic                hazard;
  logic                mdBusy;
  logic [15:0]         stallCycles;

  modport master (
    output idRs, idRt, idUsesRt, idUsesHiLo, idMdStart,
           exMemRead, exRt, exMdStart, branchTaken,
    input  pcWrite, ifidWrite, ifidFlush, idexBubble, hazard,
           mdBusy, stallCycles
  );

  modport slave (
    input  idRs, idRt, idUsesRt, idUsesHiLo, idMdStart,
           exMemRead, exRt, exMdStart, branchTaken,
    output pcWrite, ifidWrite, ifidFlush, idexBubble, hazard,
           mdBusy, stallCycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the five-stage pipeline: load-use stalls,
// taken-branch flushes and mul/div dependency holds, with a saturating
// stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int unsigned MULDIV_CYCLES = 8,
  parameter int unsigned REG_BITS      = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  localparam logic [REG_BITS-1:0] REG_ZERO = '0;
  localparam logic [7:0]          CNT_LOAD = 8'(MULDIV_CYCLES - 1);

  state_t      state, state_next;
  logic [7:0]  cnt, cnt_next;
  logic [15:0] stall_count;
  logic        load_use;
  logic        md_dep;
  logic        stall;

  // Hazard detection; a taken branch makes the ID instruction wrong-path,
  // so it overrides any stall.
  always_comb begin
    load_use = bus.exMemRead && (bus.exRt != REG_ZERO) &&
               ((bus.exRt == bus.idRs) ||
                (bus.idUsesRt && (bus.exRt == bus.idRt)));
    md_dep   = (state == MD_BUSY) && (bus.idUsesHiLo || bus.idMdStart);
    stall    = (load_use || md_dep) && !bus.branchTaken;
  end

  // State register and mul/div down-counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state: a start while already busy is ignored, and branches never
  // cancel the in-flight operation.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      RUN: begin
        if (bus.exMdStart) begin
          state_next = MD_BUSY;
          cnt_next   = CNT_LOAD;
        end
      end
      MD_BUSY: begin
        if (cnt == 8'd0) begin
          state_next = RUN;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

  // Pipeline control outputs, forced to a flushed/held pattern during reset.
  always_comb begin
    bus.pcWrite     = !stall;
    bus.ifidWrite   = !stall;
    bus.ifidFlush   = bus.branchTaken;
    bus.idexBubble  = stall || bus.branchTaken;
    bus.hazard      = stall;
    bus.mdBusy      = (state == MD_BUSY);
    bus.stallCycles = stall_count;
    if (reset) begin
      bus.pcWrite    = 1'b0;
      bus.ifidWrite  = 1'b0;
      bus.ifidFlush  = 1'b1;
      bus.idexBubble = 1'b1;
      bus.hazard     = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: the driver applies directed
// vectors and queues hand-computed expectations; the monitor checks them.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic        pc;
    logic        ifw;
    logic        fl;
    logic        bub;
    logic        hz;
    logic        md;
    logic [15:0] sc;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  bit   drive_done;

  exp_t  exp_q[$];
  string name_q[$];

  pipeline_hazard_ctrl_if #(.REG_BITS(5)) bus ();

  pipeline_hazard_ctrl #(
    .MULDIV_CYCLES(4),
    .REG_BITS     (5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt,
                        input logic usesRt, input logic hilo, input logic idMd,
                        input logic memRead, input logic [4:0] exrt,
                        input logic exMd, input logic br);
    bus.idRs        = rs;
    bus.idRt        = rt;
    bus.idUsesRt    = usesRt;
    bus.idUsesHiLo  = hilo;
    bus.idMdStart   = idMd;
    bus.exMemRead   = memRead;
    bus.exRt        = exrt;
    bus.exMdStart   = exMd;
    bus.branchTaken = br;
  endtask

  task automatic idle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic expect_out(input logic pc, input logic ifw, input logic fl,
                            input logic bub, input logic hz, input logic md,
                            input logic [15:0] sc, input string nm);
    exp_t e;
    e.pc = pc; e.ifw = ifw; e.fl = fl; e.bub = bub;
    e.hz = hz; e.md = md; e.sc = sc;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  initial begin
    exp_t  e;
    exp_t  a;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a.pc  = bus.pcWrite;
        a.ifw = bus.ifidWrite;
        a.fl  = bus.ifidFlush;
        a.bub = bus.idexBubble;
        a.hz  = bus.hazard;
        a.md  = bus.mdBusy;
        a.sc  = bus.stallCycles;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got pc=%b ifw=%b fl=%b bub=%b hz=%b md=%b sc=%h, want pc=%b ifw=%b fl=%b bub=%b hz=%b md=%b sc=%h",
                   nm, a.pc, a.ifw, a.fl, a.bub, a.hz, a.md, a.sc,
                   e.pc, e.ifw, e.fl, e.bub, e.hz, e.md, e.sc);
        end
      end
    end
  end

  // Driver: one set of inputs and one expectation per cycle.
  initial begin
    checks     = 0;
    errors     = 0;
    drive_done = 1'b0;
    reset      = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    expect_out(0, 0, 1, 1, 0, 0, 16'd0, "reset_state");

    next_cycle(); reset = 1'b0; idle();
    expect_out(1, 1, 0, 0, 0, 0, 16'd0, "idle_after_reset");

    next_cycle(); set_in(5'd5, 5'd0, 0, 0, 0, 1, 5'd5, 0, 0);
    expect_out(0, 0, 0, 1, 1, 0, 16'd0, "load_use_rs");
    next_cycle(); idle();
    expect_out(1, 1, 0, 0, 0, 0, 16'd1, "load_use_single_stall");

    next_cycle(); set_in(5'd3, 5'd5, 0, 0, 0, 1, 5'd5, 0, 0);
    expect_out(1, 1, 0, 0, 0, 0, 16'd1, "rt_match_unused");
    next_cycle(); set_in(5'd3, 5'd5, 1, 0, 0, 1, 5'd5, 0, 0);
    expect_out(0, 0, 0, 1, 1, 0, 16'd1, "load_use_rt");

    next_cycle(); set_in(5'd5, 5'd0, 0, 0, 0, 1, 5'd5, 0, 1);
    expect_out(1, 1, 1, 1, 0, 0, 16'd2, "branch_over_stall");
    next_cycle(); idle();
    expect_out(1, 1, 0, 0, 0, 0, 16'd2, "branch_no_count");

    next_cycle(); set_in(5'd0, 5'd0, 1, 0, 0, 1, 5'd0, 0, 0);
    expect_out(1, 1, 0, 0, 0, 0, 16'd2, "r0_no_hazard");

    // Mul/div start, then a dependent mfhi held in ID.
    next_cycle(); set_in(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 0);
    expect_out(1, 1, 0, 0, 0, 0, 16'd2, "md_start");
    for (int unsigned k = 0; k < 4; k++) begin
      next_cycle(); set_in(5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 0, 0);
      expect_out(0, 0, 0, 1, 1, 1, 16'(2 + k), "mfhi_stall");
    end
    next_cycle(); set_in(5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 0, 0);
    expect_out(1, 1, 0, 0, 0, 0, 16'd6, "mfhi_issue");

    // Combined load-use + mul/div dependency, then an ignored restart.
    next_cycle(); set_in(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 0);
    expect_out(1, 1, 0, 0, 0, 0, 16'd6, "md_start2");
    next_cycle(); set_in(5'd7, 5'd0, 0, 1, 0, 1, 5'd7, 0, 0);
    expect_out(0, 0, 0, 1, 1, 1, 16'd6, "combined_stall");
    next_cycle(); set_in(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 0);
    expect_out(1, 1, 0, 0, 0, 1, 16'd7, "combined_counts_once");
    next_cycle(); idle();
    expect_out(1, 1, 0, 0, 0, 1, 16'd7, "busy_3");
    next_cycle(); idle();
    expect_out(1, 1, 0, 0, 0, 1, 16'd7, "busy_4");
    next_cycle(); idle();
    expect_out(1, 1, 0, 0, 0, 0, 16'd7, "restart_ignored");

    // Reset during the second MD_BUSY cycle.
    next_cycle(); set_in(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 0);
    expect_out(1, 1, 0, 0, 0, 0, 16'd7, "md_start3");
    next_cycle(); set_in(5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 0, 0);
    expect_out(0, 0, 0, 1, 1, 1, 16'd7, "md3_stall");
    next_cycle(); reset = 1'b1;
    expect_out(0, 0, 1, 1, 0, 1, 16'd8, "reset_forced_outputs");
    next_cycle(); reset = 1'b0; idle();
    expect_out(1, 1, 0, 0, 0, 0, 16'd0, "after_mid_reset");

    // Saturation: a continuously held load-use hazard.
    next_cycle(); set_in(5'd9, 5'd0, 0, 0, 0, 1, 5'd9, 0, 0);
    expect_out(0, 0, 0, 1, 1, 0, 16'd0, "sat_first_stall");
    repeat (70000) next_cycle();
    expect_out(0, 0, 0, 1, 1, 0, 16'hFFFF, "sat_held");
    next_cycle(); idle();
    expect_out(1, 1, 0, 0, 0, 0, 16'hFFFF, "sat_no_wrap");

    next_cycle();
    drive_done = 1'b1;
  end

  initial begin
    wait (drive_done);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: driver did not complete, want completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
